irom_fetch_ctrl: RTL and testbench

Sequences the DLX instruction ROM on behalf of the fetch stage. It converts single-instruction requests into double-word line reads, and keeps the last line in a one-line buffer so the sibling word costs one cycle. It obeys the ROM's ENABLE/DATA_READY protocol and flags misaligned, out-of-range and timed-out accesses. It sits between the fetch stage and the instruction ROM.

---
 rtl/dlx_fetch_pkg.sv | 18 +
 rtl/fetch_line_buf.sv | 45 ++++
 rtl/irom_fetch_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_irom_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_fetch_pkg.sv
// Shared types for the DLX instruction fetch controller.
//   fetch_state_t     : controller states
//   line_t            : one double-word ROM line {word base+1, word base}
//   WORD_SIZE_DEFAULT : default instruction width
package dlx_fetch_pkg;

  localparam int unsigned WORD_SIZE_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    REQ  = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef logic [2*WORD_SIZE_DEFAULT-1:0] line_t;

endpackage

// File: rtl/fetch_line_buf.sv
// One-line instruction buffer: tag, valid bit, line register and word select.
//   i_load/i_load_tag/i_load_line : capture a ROM line under its base index
//   i_flush                       : invalidate (wins over load)
//   i_lookup                      : word index being requested
//   o_hit_c/o_word_c              : combinational hit flag and selected word
module fetch_line_buf #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned IDX_W     = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_flush,
  input  logic [IDX_W-1:0]       i_load_tag,
  input  logic [2*WORD_SIZE-1:0] i_load_line,
  input  logic [IDX_W-1:0]       i_lookup,
  output logic                   o_hit_c,
  output logic [WORD_SIZE-1:0]   o_word_c
);

  logic                   r_valid;
  logic [IDX_W-1:0]       r_tag;
  logic [2*WORD_SIZE-1:0] r_line;
  logic [IDX_W-1:0]       w_lookup_base;

  // Line storage; flush only clears valid, stale data is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_line  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_load_tag;
      r_line  <= i_load_line;
    end
  end

  assign w_lookup_base = {i_lookup[IDX_W-1:1], 1'b0};
  assign o_hit_c       = r_valid && (r_tag == w_lookup_base);
  assign o_word_c      = i_lookup[0] ? r_line[2*WORD_SIZE-1:WORD_SIZE] : r_line[WORD_SIZE-1:0];

endmodule

// File: rtl/irom_fetch_ctrl.sv
// Fetch-stage sequencer for the DLX instruction ROM.
// Turns word requests into double-word line reads, serves the sibling word
// from a one-line buffer, follows the ROM ENABLE/DATA_READY handshake and
// reports misaligned, out-of-range and timed-out fetches via cpu_err.
//   cpu_req/cpu_addr/cpu_flush : fetch-stage request side
//   cpu_ready/cpu_instr/cpu_err: registered response pulse
//   busy                       : controller not in IDLE
//   rom_*                      : instruction ROM interface
module irom_fetch_ctrl
  import dlx_fetch_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = WORD_SIZE_DEFAULT,
  parameter int unsigned ENTRIES        = 128,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic                   cpu_flush,
  output logic                   cpu_ready,
  output logic [WORD_SIZE-1:0]   cpu_instr,
  output logic                   cpu_err,
  output logic                   busy,
  output logic [WORD_SIZE-1:0]   rom_address,
  output logic                   rom_enable,
  input  logic                   rom_data_ready,
  input  logic [2*WORD_SIZE-1:0] rom_data
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  fetch_state_t           r_state, w_state_nxt;
  logic                   r_cpu_ready, w_cpu_ready_nxt;
  logic [WORD_SIZE-1:0]   r_cpu_instr, w_cpu_instr_nxt;
  logic                   r_cpu_err, w_cpu_err_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [WORD_SIZE-1:0]   r_rom_address, w_rom_address_nxt;
  logic                   r_rom_enable, w_rom_enable_nxt;
  logic [WD_W-1:0]        r_wd, w_wd_nxt;
  logic [IDX_W-1:0]       r_base, w_base_nxt;
  logic                   r_sel, w_sel_nxt;

  logic [IDX_W-1:0]       w_word;
  logic [IDX_W-1:0]       w_base;
  logic [IDX_W:0]         w_base_p1;
  logic                   w_misalign;
  logic                   w_oor;
  logic                   w_hit;
  logic [WORD_SIZE-1:0]   w_buf_word;
  logic                   w_buf_load;
  logic                   w_buf_clr;

  // Address decode of the incoming request.
  assign w_word     = cpu_addr[ADDR_W-1:2];
  assign w_base     = {w_word[IDX_W-1:1], 1'b0};
  assign w_base_p1  = {1'b0, w_base} + (IDX_W+1)'(1);
  assign w_misalign = (cpu_addr[1:0] != 2'b00);
  assign w_oor      = (w_base_p1 >= (IDX_W+1)'(ENTRIES));

  fetch_line_buf #(
    .WORD_SIZE (WORD_SIZE),
    .IDX_W     (IDX_W)
  ) u_line_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_buf_load),
    .i_flush     (w_buf_clr),
    .i_load_tag  (r_base),
    .i_load_line (rom_data),
    .i_lookup    (w_word),
    .o_hit_c     (w_hit),
    .o_word_c    (w_buf_word)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cpu_ready   <= 1'b0;
      r_cpu_instr   <= '0;
      r_cpu_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_rom_address <= '0;
      r_rom_enable  <= 1'b0;
      r_wd          <= '0;
      r_base        <= '0;
      r_sel         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cpu_ready   <= w_cpu_ready_nxt;
      r_cpu_instr   <= w_cpu_instr_nxt;
      r_cpu_err     <= w_cpu_err_nxt;
      r_busy        <= w_busy_nxt;
      r_rom_address <= w_rom_address_nxt;
      r_rom_enable  <= w_rom_enable_nxt;
      r_wd          <= w_wd_nxt;
      r_base        <= w_base_nxt;
      r_sel         <= w_sel_nxt;
    end
  end

  // Next-state and output decode.  Because cpu_ready is registered, a flush
  // seen when a response would be scheduled cancels that response.
  always_comb begin
    w_state_nxt       = r_state;
    w_cpu_ready_nxt   = 1'b0;
    w_cpu_err_nxt     = 1'b0;
    w_cpu_instr_nxt   = r_cpu_instr;
    w_rom_address_nxt = r_rom_address;
    w_rom_enable_nxt  = r_rom_enable;
    w_wd_nxt          = r_wd;
    w_base_nxt        = r_base;
    w_sel_nxt         = r_sel;
    w_buf_load        = 1'b0;
    w_buf_clr         = cpu_flush;

    unique case (r_state)
      IDLE: begin
        if (!cpu_flush && cpu_req) begin
          if (w_misalign || w_oor) begin
            w_state_nxt     = RESP;
            w_cpu_ready_nxt = 1'b1;
            w_cpu_err_nxt   = 1'b1;
          end else if (w_hit) begin
            w_state_nxt     = RESP;
            w_cpu_ready_nxt = 1'b1;
            w_cpu_instr_nxt = w_buf_word;
          end else begin
            w_state_nxt       = REQ;
            w_rom_enable_nxt  = 1'b1;
            w_rom_address_nxt = WORD_SIZE'(w_base);
            w_wd_nxt          = '0;
            w_base_nxt        = w_base;
            w_sel_nxt         = w_word[0];
          end
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      REQ: begin
        if (cpu_flush) begin
          w_state_nxt      = DROP;
          w_rom_enable_nxt = 1'b0;
        end else if (rom_data_ready) begin
          w_state_nxt      = DROP;
          w_rom_enable_nxt = 1'b0;
          w_buf_load       = 1'b1;
          w_cpu_ready_nxt  = 1'b1;
          w_cpu_instr_nxt  = r_sel ? rom_data[2*WORD_SIZE-1:WORD_SIZE] : rom_data[WORD_SIZE-1:0];
        end else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt      = DROP;
          w_rom_enable_nxt = 1'b0;
          w_cpu_ready_nxt  = 1'b1;
          w_cpu_err_nxt    = 1'b1;
          w_buf_clr        = 1'b1;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
      end
      DROP: begin
        // Wait for the ROM to release DATA_READY; any data here is stale.
        w_rom_enable_nxt = 1'b0;
        if (!rom_data_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign cpu_ready   = r_cpu_ready;
  assign cpu_instr   = r_cpu_instr;
  assign cpu_err     = r_cpu_err;
  assign busy        = r_busy;
  assign rom_address = r_rom_address;
  assign rom_enable  = r_rom_enable;

endmodule

// File: tb/tb_irom_fetch_ctrl.sv
// Randomized scoreboard bench for irom_fetch_ctrl with a latency-aware ROM model.
module tb_irom_fetch_ctrl;
  import dlx_fetch_pkg::*;

  localparam int unsigned ENTRIES = 128;
  localparam int unsigned TO      = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_flush = 1'b0;
  logic        cpu_ready, cpu_err, busy, rom_enable;
  logic [31:0] cpu_instr, rom_address;
  logic        rom_rdy;
  line_t       rom_data;

  irom_fetch_ctrl #(
    .WORD_SIZE(32), .ENTRIES(ENTRIES), .TIMEOUT_CYCLES(TO), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_flush(cpu_flush), .cpu_ready(cpu_ready), .cpu_instr(cpu_instr),
    .cpu_err(cpu_err), .busy(busy), .rom_address(rom_address),
    .rom_enable(rom_enable), .rom_data_ready(rom_rdy), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: DATA_READY rises D+1 cycles after ENABLE is first seen, held while ENABLE.
  logic [31:0] rom_mem [ENTRIES];
  int          rom_d = 2;
  bit          rom_dead = 1'b0;
  int          rom_cnt;
  logic [6:0]  ia, ia1;
  assign ia  = rom_address[6:0];
  assign ia1 = ia + 7'd1;
  assign rom_data = rom_rdy ? {rom_mem[ia1], rom_mem[ia]} : {2{32'hDEADBEEF}};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cnt <= 0;
      rom_rdy <= 1'b0;
    end else if (!rom_enable) begin
      rom_cnt <= 0;
      rom_rdy <= 1'b0;
    end else begin
      if (!rom_dead && rom_cnt == rom_d) rom_rdy <= 1'b1;
      if (rom_cnt < 1000) rom_cnt <= rom_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Reference buffer state: which line (if any) the fetch unit should hold.
  bit          m_valid = 1'b0;
  int unsigned m_tag   = 0;

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (!cpu_ready) chk("err_without_ready", cpu_err, 1'b0);
      else if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ready: got ready with instr 0x%0h err %0b, expected none (cycle %0d)",
                 cpu_instr, cpu_err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", cpu_err, e.err);
        if (!e.err) chk("resp_instr", cpu_instr, e.instr);
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic idle_flush();
    wait_idle();
    cpu_flush = 1'b1;
    @(negedge clk);
    cpu_flush = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a);
    exp_t        e;
    int unsigned w, b;
    bit          miss, tmo, got, en_seen;
    logic [31:0] seen_addr;
    wait_idle();
    w = a >> 2;
    b = w & ~32'd1;
    miss = 1'b0; tmo = 1'b0;
    e.instr = '0; e.err = 1'b0;
    if (a[1:0] != 2'b00 || b + 1 >= ENTRIES) begin
      e.err = 1'b1; e.cyc = cyc + 1;
    end else if (m_valid && m_tag == b) begin
      e.instr = rom_mem[w]; e.cyc = cyc + 1;
    end else begin
      miss = 1'b1;
      if (rom_dead) begin
        tmo = 1'b1; e.err = 1'b1; e.cyc = cyc + 1 + TO; m_valid = 1'b0;
      end else begin
        e.instr = rom_mem[w]; e.cyc = cyc + rom_d + 3; m_valid = 1'b1; m_tag = b;
      end
    end
    sb.push_back(e);
    cpu_req = 1'b1; cpu_addr = a;
    got = 1'b0; en_seen = 1'b0; seen_addr = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rom_enable) begin en_seen = 1'b1; seen_addr = rom_address; end
      if (cpu_ready) got = 1'b1;
    end
    cpu_req = 1'b0;
    if (!got) begin
      chk("ready_wait_expired", got, 1'b1);
      sb.delete();
    end
    chk("rom_accessed", en_seen, miss);
    if (miss) chk("rom_address", seen_addr, b);
    if (tmo) begin
      chk("enable_after_timeout", rom_enable, 1'b0);
      wait_idle();
      chk("busy_after_timeout", busy, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench still running, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < ENTRIES; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'hAABB0011;
    rom_mem[1] = 32'h12345678;

    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_rom_enable", rom_enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cpu_instr", cpu_instr, 32'h0);
    chk("rst_rom_address", rom_address, 32'h0);
    rst = 1'b0;

    // Cold miss then sibling hit.
    rom_d = 2;
    do_req(32'h00);
    do_req(32'h04);
    // Misaligned, last valid line, first out-of-range line.
    do_req(32'h06);
    do_req(32'h1FC);
    do_req(32'h200);

    // Flush during the second REQ cycle aborts the read silently.
    wait_idle();
    cpu_req = 1'b1; cpu_addr = 32'h08;
    @(negedge clk);
    @(negedge clk);
    chk("flush_pre_enable", rom_enable, 1'b1);
    cpu_flush = 1'b1;
    @(negedge clk);
    cpu_flush = 1'b0; cpu_req = 1'b0;
    chk("flush_enable_drop", rom_enable, 1'b0);
    m_valid = 1'b0;
    do_req(32'h0C);

    // ROM never answers: watchdog error.
    rom_dead = 1'b1;
    do_req(32'h20);
    rom_dead = 1'b0;

    // Asynchronous reset mid-read invalidates the buffered line 0.
    do_req(32'h00);
    wait_idle();
    rom_dead = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h10;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_enable", rom_enable, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", cpu_ready, 1'b0);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rom_dead = 1'b0;
    m_valid = 1'b0;
    do_req(32'h04);

    // Randomized traffic.
    begin
      logic [31:0] last;
      last = 32'h04;
      for (int t = 0; t < 70; t++) begin
        int unsigned k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        rom_d = $urandom_range(0, 3);
        rom_dead = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 7) == 0) idle_flush();
        case (k)
          0:       a = ($urandom_range(0, 127) << 2) | $urandom_range(1, 3);
          1:       a = $urandom_range(128, 4000) << 2;
          2, 3, 4: a = last ^ 32'h4;
          default: a = $urandom_range(0, 127) << 2;
        endcase
        do_req(a);
        last = a;
      end
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
